// File: rtl/csa_resolve_seq.sv
// csa_resolve_seq: serial carry-propagate resolve of a carry-save pair, SLICE bits per clock.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with s_in[WIDTH-1:0] and c_in[WIDTH:0];
// out_valid/out_ready with result[WIDTH+1:0] = s_in + c_in.
// Optional: define CSA_RESOLVE_ZERO_EN to add the registered out_zero flag (result == 0).
module csa_resolve_seq #(
  parameter int WIDTH = 23,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH:0]   c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] result
`ifdef CSA_RESOLVE_ZERO_EN
  ,
  output logic             out_zero
`endif
);
  localparam int NS = (WIDTH + SLICE) / SLICE;
  localparam int PW = NS * SLICE;
  localparam int RW = WIDTH + 2;
  localparam int CW = NS > 1 ? $clog2(NS) : 1;
  localparam logic [PW:0] ONES = (PW+1)'({SLICE{1'b1}});
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] s_reg, c_reg;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          last;
  logic [SLICE:0] sum;
`ifdef CSA_RESOLVE_ZERO_EN
  logic nz;
`endif
  assign last = cnt == CW'(NS - 1);
  assign sum  = {1'b0, s_reg[cnt*SLICE +: SLICE]} + {1'b0, c_reg[cnt*SLICE +: SLICE]} + (SLICE+1)'(carry);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    state_nx  = state == IDLE ? (in_valid ? ADD : IDLE) :
                state == ADD  ? (last ? DONE : ADD) :
                                (out_ready ? IDLE : DONE);
  end
  // Slices land in place through a shifted mask; padding bits above result are dropped by the casts.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_reg  <= '0;
      c_reg  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      result <= '0;
`ifdef CSA_RESOLVE_ZERO_EN
      nz       <= 1'b0;
      out_zero <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      s_reg <= PW'(s_in);
      c_reg <= PW'(c_in);
      cnt   <= '0;
      carry <= 1'b0;
`ifdef CSA_RESOLVE_ZERO_EN
      nz       <= 1'b0;
      out_zero <= 1'b0;
`endif
    end else if (state == ADD) begin
      result <= (result & ~RW'(ONES << (cnt*SLICE))) | RW'((PW+1)'(sum[SLICE-1:0]) << (cnt*SLICE));
      if (last && PW < RW) result[RW-1] <= sum[SLICE];
      carry <= sum[SLICE];
      cnt   <= cnt + CW'(1);
`ifdef CSA_RESOLVE_ZERO_EN
      nz <= nz | (|sum);
      if (last) out_zero <= ~(nz | (|sum));
`endif
    end
`ifdef CSA_RESOLVE_ZERO_EN
    else if (state == DONE && out_ready) out_zero <= 1'b0;
`endif
endmodule

// File: tb/tb_csa_resolve_seq.sv
// tb_csa_resolve_seq: directed plus random checks of csa_resolve_seq against plain-integer addition.
module tb_csa_resolve_seq;
  localparam int W  = 23;
  localparam int NS = 3;
  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid;
  logic [W-1:0] s_in = '0;
  logic [W:0]   c_in = '0;
  logic [W+1:0] result;
  logic [W+1:0] last_res = '0;
  int n = 0, nf = 0;
`ifdef CSA_RESOLVE_ZERO_EN
  logic out_zero;
`endif
  always #5 clk = ~clk;
  csa_resolve_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .s_in(s_in), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
`ifdef CSA_RESOLVE_ZERO_EN
    , .out_zero(out_zero)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n++;
    assert (obs === exp) else begin
      nf++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [W-1:0] s, input logic [W:0] c, input int bp, input bit busy);
    logic [W+1:0] e;
    e = {2'b0, s} + {1'b0, c};
    chk("idle_ready", 64'(in_ready), 1);
    chk("idle_valid", 64'(out_valid), 0);
    chk("idle_hold", 64'(result), 64'(last_res));
    s_in = s;
    c_in = c;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    s_in = W'($urandom);
    c_in = (W+1)'($urandom);
    for (int i = 1; i < NS; i++) begin
      if (busy && i == 1) begin
        in_valid = 1'b1;
        s_in = 23'h123456;
      end
      tick;
      in_valid = 1'b0;
      chk("lat_valid", 64'(out_valid), 0);
      chk("busy_ready", 64'(in_ready), 0);
    end
    tick;
    chk("done_valid", 64'(out_valid), 1);
    chk("result", 64'(result), 64'(e));
`ifdef CSA_RESOLVE_ZERO_EN
    chk("zero", 64'(out_zero), 64'(e == 0));
`endif
    for (int i = 0; i < bp; i++) begin
      tick;
      chk("bp_valid", 64'(out_valid), 1);
      chk("bp_ready", 64'(in_ready), 0);
      chk("bp_result", 64'(result), 64'(e));
`ifdef CSA_RESOLVE_ZERO_EN
      chk("bp_zero", 64'(out_zero), 64'(e == 0));
`endif
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("ret_valid", 64'(out_valid), 0);
    chk("ret_ready", 64'(in_ready), 1);
    chk("ret_hold", 64'(result), 64'(e));
    last_res = e;
  endtask
  initial begin
    tick;
    chk("rst_ready", 64'(in_ready), 1);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_result", 64'(result), 0);
    tick;
    rst_n = 1'b1;
    run(23'h7FFFFF, 24'hFFFFFF, 0, 1'b0);
    run(23'h0000FF, 24'h000001, 0, 1'b0);
    run(23'h000001, 24'h000001, 5, 1'b0);
    run(23'h000ABC, 24'h000111, 1, 1'b1);
    run(23'h000000, 24'h000000, 1, 1'b0);
    run(23'h000000, 24'h800000, 0, 1'b0);
    s_in = 23'h0F0F0F;
    c_in = 24'h00FFFF;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 0);
    chk("mid_rst_ready", 64'(in_ready), 1);
    chk("mid_rst_result", 64'(result), 0);
    tick;
    rst_n = 1'b1;
    last_res = '0;
    for (int i = 0; i < NS + 2; i++) begin
      tick;
      chk("dropped_valid", 64'(out_valid), 0);
    end
    for (int i = 0; i < 40; i++)
      run(W'($urandom), (W+1)'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", n, nf);
    $finish;
  end
endmodule
